// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32I pipeline.
// Holds the fetch-stage state encoding and the NOP used for pipeline bubbles.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_WAIT,
        FETCH_DROP
    } fetchState_t;

endpackage

// File: rtl/fetch_stage_flopD.sv
// IF/ID pipeline register: load on enable, flush to a NOP bubble.
// A flush keeps PCD/PCPlus4D; only reset clears them.
module flopD
    import riscv_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         dValid,
    input  logic [31:0]  dInstr,
    input  logic [W-1:0] dPC,
    input  logic [W-1:0] dPCPlus4,
    output logic         ValidD,
    output logic [31:0]  InstrD,
    output logic [W-1:0] PCD,
    output logic [W-1:0] PCPlus4D
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (clr) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP_INSTR;
        end else if (en) begin
            ValidD   <= dValid;
            InstrD   <= dInstr;
            PCD      <= dPC;
            PCPlus4D <= dPCPlus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem requests, one-entry skid buffer
// for responses that arrive while decode is stalled, and the IF/ID register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam logic [XLEN-1:0] Four = XLEN'(4);

    fetchState_t     state, stateNext;
    logic [XLEN-1:0] PCF, reqPC;
    logic            bufValid;
    logic [31:0]     bufInstr;
    logic [XLEN-1:0] bufPC;
    logic            live, issue;

    logic            dValid;
    logic [31:0]     dInstr;
    logic [XLEN-1:0] dPC, dPCPlus4;

    assign live  = imem_rvalid & (state == FETCH_WAIT) & ~PCSrcE;
    // A new request may leave only when nothing is pending (or it returns now)
    // and a stalled decode will not need the skid buffer this cycle.
    assign issue = ~reset & ~StallF & ~PCSrcE & ~bufValid
                 & ((state == FETCH_IDLE) | imem_rvalid) & ~(live & StallD);

    assign imem_req  = issue;
    assign imem_addr = PCF;

    always_comb begin
        stateNext = state;
        unique case (state)
            FETCH_IDLE: if (issue) stateNext = FETCH_WAIT;
            FETCH_WAIT: begin
                if (imem_rvalid)  stateNext = issue ? FETCH_WAIT : FETCH_IDLE;
                else if (PCSrcE)  stateNext = FETCH_DROP;
            end
            FETCH_DROP: if (imem_rvalid) stateNext = issue ? FETCH_WAIT : FETCH_IDLE;
            default:    stateNext = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH_IDLE;
            PCF      <= RESET_PC;
            reqPC    <= '0;
            bufValid <= 1'b0;
            bufInstr <= NOP_INSTR;
            bufPC    <= '0;
        end else begin
            state <= stateNext;
            if (PCSrcE)     PCF <= PCTargetE;
            else if (issue) PCF <= PCF + Four;
            if (issue) reqPC <= PCF;
            if (PCSrcE) begin
                bufValid <= 1'b0;
            end else if (!FlushD && StallD && live) begin
                bufValid <= 1'b1;
                bufInstr <= imem_rdata;
                bufPC    <= reqPC;
            end else if (!FlushD && !StallD) begin
                bufValid <= 1'b0;
            end
        end
    end

    // Buffered instruction is older than any live response, so it goes first.
    always_comb begin
        dValid   = 1'b0;
        dInstr   = NOP_INSTR;
        dPC      = PCD;
        dPCPlus4 = PCPlus4D;
        if (bufValid) begin
            dValid   = 1'b1;
            dInstr   = bufInstr;
            dPC      = bufPC;
            dPCPlus4 = bufPC + Four;
        end else if (live) begin
            dValid   = 1'b1;
            dInstr   = imem_rdata;
            dPC      = reqPC;
            dPCPlus4 = reqPC + Four;
        end
    end

    flopD #(
        .W(XLEN)
    ) u_ifid (
        .clk     (clk),
        .reset   (reset),
        .en      (~StallD),
        .clr     (FlushD),
        .dValid  (dValid),
        .dInstr  (dInstr),
        .dPC     (dPC),
        .dPCPlus4(dPCPlus4),
        .ValidD  (ValidD),
        .InstrD  (InstrD),
        .PCD     (PCD),
        .PCPlus4D(PCPlus4D)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a latency-programmable instruction memory
// whose words are a fixed function of their address.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int          nTotal = 0;
    int          nBad = 0;
    int          memLat = 1;
    logic        memBusy = 1'b0;
    int          memCnt = 0;
    logic [31:0] memAddr = '0;

    localparam logic [31:0] Nop = 32'h0000_0013;

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory: latency 1 answers in the cycle after the request.
    always @(posedge clk) begin
        if (reset) begin
            memBusy     <= 1'b0;
            imem_rvalid <= 1'b0;
        end else begin
            imem_rvalid <= 1'b0;
            if (memBusy) begin
                if (memCnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= memWord(memAddr);
                    memBusy     <= 1'b0;
                end else begin
                    memCnt <= memCnt - 1;
                end
            end
            if (imem_req) begin
                if (memLat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= memWord(imem_addr);
                end else begin
                    memBusy <= 1'b1;
                    memCnt  <= memLat - 1;
                    memAddr <= imem_addr;
                end
            end
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTotal++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after reset release, outputs settled.
    task automatic doReset(input int lat, input logic stallF);
        reset = 1'b1; StallF = stallF; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = '0; memLat = lat;
        cyc(); cyc();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state and 1-cycle memory streaming
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = '0; memLat = 1;
        cyc(); cyc();
        checkVal("rst_req", imem_req, 0);
        checkVal("rst_addr", imem_addr, 0);
        checkVal("rst_valid", ValidD, 0);
        checkVal("rst_instr", InstrD, Nop);
        checkVal("rst_pcd", PCD, 0);
        checkVal("rst_pcp4", PCPlus4D, 0);
        reset = 1'b0; #1;
        checkVal("s1_c0_req", imem_req, 1);
        checkVal("s1_c0_addr", imem_addr, 0);
        cyc();
        checkVal("s1_c1_addr", imem_addr, 32'h4);
        checkVal("s1_c1_valid", ValidD, 0);
        cyc();
        checkVal("s1_c2_valid", ValidD, 1);
        checkVal("s1_c2_pcd", PCD, 0);
        checkVal("s1_c2_instr", InstrD, memWord(32'h0));
        checkVal("s1_c2_pcp4", PCPlus4D, 32'h4);
        checkVal("s1_c2_addr", imem_addr, 32'h8);
        cyc();
        checkVal("s1_c3_pcd", PCD, 32'h4);
        cyc();
        checkVal("s1_c4_pcd", PCD, 32'h8);
        FlushD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h200; #1;
        checkVal("s1_redir_req", imem_req, 0);
        cyc();
        FlushD = 1'b0; PCSrcE = 1'b0; #1;
        checkVal("s1_flush_valid", ValidD, 0);
        checkVal("s1_flush_instr", InstrD, Nop);
        checkVal("s1_flush_pcd", PCD, 32'h8);
        checkVal("s1_flush_req", imem_req, 1);
        checkVal("s1_flush_addr", imem_addr, 32'h200);
        cyc(); cyc();
        checkVal("s1_tgt_valid", ValidD, 1);
        checkVal("s1_tgt_pcd", PCD, 32'h200);

        // 3-cycle memory latency
        doReset(3, 1'b0);
        checkVal("s2_c0_req", imem_req, 1);
        cyc();
        checkVal("s2_c1_req", imem_req, 0);
        cyc(); cyc();
        checkVal("s2_c3_req", imem_req, 1);
        checkVal("s2_c3_addr", imem_addr, 32'h4);
        cyc();
        checkVal("s2_c4_valid", ValidD, 1);
        checkVal("s2_c4_pcd", PCD, 0);
        checkVal("s2_c4_req", imem_req, 0);
        cyc();
        checkVal("s2_c5_valid", ValidD, 0);
        checkVal("s2_c5_instr", InstrD, Nop);
        cyc();
        checkVal("s2_c6_addr", imem_addr, 32'h8);
        cyc();
        checkVal("s2_c7_pcd", PCD, 32'h4);
        cyc(); cyc(); cyc();
        checkVal("s2_c10_valid", ValidD, 1);
        checkVal("s2_c10_pcd", PCD, 32'h8);

        // StallD over the PC=8 response: skid buffer holds it
        doReset(1, 1'b0);
        cyc(); cyc(); cyc();
        checkVal("s3_c3_pcd", PCD, 32'h4);
        StallD = 1'b1; #1;
        checkVal("s3_c3_req", imem_req, 0);
        cyc();
        checkVal("s3_c4_req", imem_req, 0);
        checkVal("s3_c4_pcd", PCD, 32'h4);
        cyc();
        checkVal("s3_c5_pcd", PCD, 32'h4);
        cyc();
        StallD = 1'b0; #1;
        checkVal("s3_c6_req", imem_req, 0);
        cyc();
        checkVal("s3_c7_pcd", PCD, 32'h8);
        checkVal("s3_c7_instr", InstrD, memWord(32'h8));
        checkVal("s3_c7_req", imem_req, 1);
        checkVal("s3_c7_addr", imem_addr, 32'hC);
        cyc();
        checkVal("s3_c8_valid", ValidD, 0);
        cyc();
        checkVal("s3_c9_pcd", PCD, 32'hC);
        checkVal("s3_c9_instr", InstrD, memWord(32'hC));

        // Redirect while waiting: late response must be dropped
        doReset(3, 1'b0);
        PCSrcE = 1'b1; PCTargetE = 32'h20; #1;
        checkVal("s4_c0_req", imem_req, 0);
        cyc();
        PCSrcE = 1'b0; #1;
        checkVal("s4_c1_addr", imem_addr, 32'h20);
        checkVal("s4_c1_req", imem_req, 1);
        cyc();
        PCSrcE = 1'b1; PCTargetE = 32'h100; #1;
        checkVal("s4_c2_req", imem_req, 0);
        cyc();
        PCSrcE = 1'b0; #1;
        checkVal("s4_c3_req", imem_req, 0);
        checkVal("s4_c3_addr", imem_addr, 32'h100);
        cyc();
        checkVal("s4_c4_req", imem_req, 1);
        checkVal("s4_c4_addr", imem_addr, 32'h100);
        cyc();
        checkVal("s4_c5_valid", ValidD, 0);
        cyc(); cyc();
        checkVal("s4_c7_addr", imem_addr, 32'h104);
        cyc();
        checkVal("s4_c8_valid", ValidD, 1);
        checkVal("s4_c8_pcd", PCD, 32'h100);
        checkVal("s4_c8_instr", InstrD, memWord(32'h100));

        // Redirect while StallF held
        doReset(1, 1'b1);
        PCSrcE = 1'b1; PCTargetE = 32'h40; #1;
        checkVal("s5_c0_req", imem_req, 0);
        cyc();
        PCSrcE = 1'b0; #1;
        checkVal("s5_c1_addr", imem_addr, 32'h40);
        checkVal("s5_c1_req", imem_req, 0);
        cyc();
        StallF = 1'b0; #1;
        checkVal("s5_c2_req", imem_req, 1);
        checkVal("s5_c2_addr", imem_addr, 32'h40);
        cyc(); cyc();
        checkVal("s5_c4_pcd", PCD, 32'h40);

        // PC wrap at the top of the address space
        doReset(1, 1'b0);
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; #1;
        cyc();
        PCSrcE = 1'b0; #1;
        checkVal("s6_c1_addr", imem_addr, 32'hFFFF_FFFC);
        cyc();
        checkVal("s6_c2_addr", imem_addr, 0);
        cyc();
        checkVal("s6_c3_pcd", PCD, 32'hFFFF_FFFC);
        checkVal("s6_c3_pcp4", PCPlus4D, 0);
        checkVal("s6_c3_instr", InstrD, memWord(32'hFFFF_FFFC));
        cyc();
        checkVal("s6_c4_pcd", PCD, 0);

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
